// File: rtl/operand_wb_pkg.sv
// Shared types and constants for the operand/write-back datapath stage.
//   state_t : operation sequencer states
//   ALU_*   : ALU opcodes carried on ALUop
//   SH_*    : B-operand shift codes
//   ctrl_t  : per-operation controls latched at start
package operand_wb_pkg;

  localparam int unsigned W_DEFAULT = 16;
  localparam int unsigned NREG      = 8;
  localparam int unsigned REG_AW    = $clog2(NREG);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  typedef struct packed {
    logic [1:0]        op;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rm;
    logic [REG_AW-1:0] rd;
    logic [1:0]        shift;
    logic              asel;
    logic              bsel;
    logic              wb_en;
  } ctrl_t;

endpackage

// File: rtl/regfile_8x16.sv
// Register file: NREG words of W bits.
//   clk, reset          : clock, synchronous active-high clear of all words
//   write/writenum/data_in : synchronous write port
//   readnum/data_out    : combinational read port
module regfile_8x16
  import operand_wb_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [REG_AW-1:0] writenum,
  input  logic [W-1:0]      data_in,
  input  logic [REG_AW-1:0] readnum,
  output logic [W-1:0]      data_out
);

  logic [W-1:0] regs_q [NREG];

  // Reset clear has priority, so a write in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else if (write) begin
      regs_q[writenum] <= data_in;
    end
  end

  assign data_out = regs_q[readnum];

endmodule

// File: rtl/operand_wb_stage.sv
// Register-file datapath stage around an external ALU. One operation per
// start pulse: read Rn -> A, read Rm -> B, present operands, capture result
// into C/status, optionally write C back to Rd.
//   clk, reset                 : clock, synchronous active-high reset
//   start, op, rn, rm, rd,
//   shift, asel, bsel, sximm5,
//   wb_en                      : operation request, latched in IDLE on start
//   ext_we/ext_wnum/ext_wdata  : external register write, IDLE only
//   alu_out, alu_z/n/v         : ALU result and flags
//   Ain, Bin, ALUop, alu_valid : ALU operands (qualify with alu_valid)
//   datapath_out, status       : C register and {Z,N,V}
//   busy, done                 : not-IDLE indicator, WRITE-cycle pulse
module operand_wb_stage
  import operand_wb_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [W-1:0]      sximm5,
  input  logic              wb_en,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_wnum,
  input  logic [W-1:0]      ext_wdata,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic [W-1:0]      Ain,
  output logic [W-1:0]      Bin,
  output logic [1:0]        ALUop,
  output logic              alu_valid,
  output logic [W-1:0]      datapath_out,
  output logic [2:0]        status,
  output logic              busy,
  output logic              done
);

  state_t       state_q;
  ctrl_t        ctrl_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] c_q;
  logic [2:0]   status_q;
  logic         busy_q;
  logic         done_q;
  logic         valid_q;

  logic [REG_AW-1:0] rf_raddr;
  logic [W-1:0]      rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [W-1:0]      rf_wdata;
  logic [W-1:0]      b_shifted;

  // Single read port: Rm during LOAD_B, Rn otherwise.
  assign rf_raddr = (state_q == LOAD_B) ? ctrl_q.rm : ctrl_q.rn;

  // Write port shared between the IDLE external write and the WRITE-state write-back.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ext_wnum;
    rf_wdata = ext_wdata;
    if (state_q == IDLE && ext_we) begin
      rf_we = 1'b1;
    end else if (state_q == WRITE && ctrl_q.wb_en) begin
      rf_we    = 1'b1;
      rf_waddr = ctrl_q.rd;
      rf_wdata = c_q;
    end
  end

  regfile_8x16 #(.W(W)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (rf_we),
    .writenum (rf_waddr),
    .data_in  (rf_wdata),
    .readnum  (rf_raddr),
    .data_out (rf_rdata)
  );

  // B-operand shifter: LSL/LSR fill with zero, ASR replicates the sign bit.
  always_comb begin
    b_shifted = b_q;
    case (ctrl_q.shift)
      SH_LSL1: b_shifted = {b_q[W-2:0], 1'b0};
      SH_LSR1: b_shifted = {1'b0, b_q[W-1:1]};
      SH_ASR1: b_shifted = {b_q[W-1], b_q[W-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  always_comb begin
    Ain = ctrl_q.asel ? '0 : a_q;
    Bin = ctrl_q.bsel ? imm_q : b_shifted;
  end

  // Sequencer with datapath registers; status outputs are set for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            ctrl_q  <= '{op: op, rn: rn, rm: rm, rd: rd, shift: shift,
                         asel: asel, bsel: bsel, wb_en: wb_en};
            imm_q   <= sximm5;
            state_q <= LOAD_A;
            busy_q  <= 1'b1;
          end
        end
        LOAD_A: begin
          a_q     <= rf_rdata;
          state_q <= LOAD_B;
        end
        LOAD_B: begin
          b_q     <= rf_rdata;
          state_q <= EXEC;
          valid_q <= 1'b1;
        end
        EXEC: begin
          c_q      <= alu_out;
          status_q <= {alu_z, alu_n, alu_v};
          state_q  <= WRITE;
          valid_q  <= 1'b0;
          done_q   <= 1'b1;
        end
        WRITE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ALUop        = ctrl_q.op;
  assign alu_valid    = valid_q;
  assign datapath_out = c_q;
  assign status       = status_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_operand_wb_stage.sv
module tb_operand_wb_stage;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [2:0]    rn = 3'd0;
  logic [2:0]    rm = 3'd0;
  logic [2:0]    rd = 3'd0;
  logic [1:0]    shift = 2'b00;
  logic          asel = 1'b0;
  logic          bsel = 1'b0;
  logic [W-1:0]  sximm5 = '0;
  logic          wb_en = 1'b0;
  logic          ext_we = 1'b0;
  logic [2:0]    ext_wnum = 3'd0;
  logic [W-1:0]  ext_wdata = '0;
  logic [W-1:0]  alu_out;
  logic          alu_z, alu_n, alu_v;
  logic [W-1:0]  Ain, Bin;
  logic [1:0]    ALUop;
  logic          alu_valid;
  logic [W-1:0]  datapath_out;
  logic [2:0]    status;
  logic          busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  operand_wb_stage dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rn(rn), .rm(rm), .rd(rd),
    .shift(shift), .asel(asel), .bsel(bsel), .sximm5(sximm5), .wb_en(wb_en),
    .ext_we(ext_we), .ext_wnum(ext_wnum), .ext_wdata(ext_wdata),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .alu_valid(alu_valid),
    .datapath_out(datapath_out), .status(status), .busy(busy), .done(done)
  );

  // Reference ALU attached to the stage.
  logic [W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      2'b00: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[W-1] == Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      2'b01: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[W-1] != Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      2'b10:   alu_res = Ain & Bin;
      default: alu_res = ~Bin;
    endcase
    alu_z = (alu_res == '0);
    alu_n = alu_res[W-1];
  end
  assign alu_out = alu_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input logic [2:0] n, input logic [W-1:0] d);
    ext_we = 1'b1; ext_wnum = n; ext_wdata = d;
    tick();
    ext_we = 1'b0;
  endtask

  // Issue one op and wait (bounded) for done, then let WRITE complete.
  // lat counts clock edges from the start-sampling edge to the cycle done is seen.
  task automatic run_op(input logic [1:0] o, input logic [2:0] n, input logic [2:0] m,
                        input logic [2:0] d, input logic [1:0] sh, input logic as,
                        input logic bs, input logic [W-1:0] imm, input logic we,
                        output logic got, output int lat,
                        output logic [W-1:0] ain_x, output logic [W-1:0] bin_x);
    op = o; rn = n; rm = m; rd = d; shift = sh; asel = as; bsel = bs;
    sximm5 = imm; wb_en = we;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; got = 1'b0; ain_x = '0; bin_x = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (alu_valid) begin ain_x = Ain; bin_x = Bin; end
      if (done) got = 1'b1;
      else begin tick(); lat++; end
    end
    if (got) tick();
  endtask

  // Read a register through the datapath: Ain=0, Bin=R[r], no write-back.
  task automatic read_reg(input logic [2:0] r, output logic [W-1:0] val, output logic got);
    int lat;
    logic [W-1:0] ax, bx;
    run_op(2'b00, 3'd0, r, 3'd0, 2'b00, 1'b1, 1'b0, '0, 1'b0, got, lat, ax, bx);
    val = datapath_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", alu_valid); end
    n_tests++; if (datapath_out !== 16'h0000) begin n_fail++; $display("FAIL reset_c got=%h exp=0000", datapath_out); end
    n_tests++; if (status !== 3'b000) begin n_fail++; $display("FAIL reset_status got=%b exp=000", status); end
    n_tests++; if (Ain !== 16'h0000 || Bin !== 16'h0000) begin n_fail++; $display("FAIL reset_operands got=%h/%h exp=0000/0000", Ain, Bin); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_shifted_add();
    logic got, rgot; int lat; logic [W-1:0] ax, bx, v;
    ext_write(3'd0, 16'd7);
    ext_write(3'd1, 16'd2);
    run_op(2'b00, 3'd0, 3'd1, 3'd2, 2'b01, 1'b0, 1'b0, '0, 1'b1, got, lat, ax, bx);
    n_tests++; if (got !== 1'b1 || lat != 4) begin n_fail++; $display("FAIL add_done_latency got=%b/%0d exp=1/4", got, lat); end
    n_tests++; if (ax !== 16'd7) begin n_fail++; $display("FAIL add_ain got=%h exp=0007", ax); end
    n_tests++; if (bx !== 16'd4) begin n_fail++; $display("FAIL add_bin_lsl got=%h exp=0004", bx); end
    n_tests++; if (datapath_out !== 16'd11) begin n_fail++; $display("FAIL add_c got=%h exp=000b", datapath_out); end
    n_tests++; if (status !== 3'b000) begin n_fail++; $display("FAIL add_status got=%b exp=000", status); end
    read_reg(3'd2, v, rgot);
    n_tests++; if (rgot !== 1'b1 || v !== 16'd11) begin n_fail++; $display("FAIL add_r2 got=%h exp=000b", v); end
  endtask

  task automatic test_overflow();
    logic got, rgot; int lat; logic [W-1:0] ax, bx, v;
    ext_write(3'd3, 16'h7FFF);
    ext_write(3'd4, 16'h0001);
    run_op(2'b00, 3'd3, 3'd4, 3'd5, 2'b00, 1'b0, 1'b0, '0, 1'b1, got, lat, ax, bx);
    n_tests++; if (datapath_out !== 16'h8000) begin n_fail++; $display("FAIL ovf_c got=%h exp=8000", datapath_out); end
    n_tests++; if (status !== 3'b011) begin n_fail++; $display("FAIL ovf_status got=%b exp=011", status); end
    read_reg(3'd5, v, rgot);
    n_tests++; if (v !== 16'h8000) begin n_fail++; $display("FAIL ovf_r5 got=%h exp=8000", v); end
  endtask

  task automatic test_compare_only();
    logic got, rgot; int lat; logic [W-1:0] ax, bx, v;
    ext_write(3'd6, 16'h1234);
    ext_write(3'd7, 16'h1234);
    run_op(2'b01, 3'd6, 3'd7, 3'd6, 2'b00, 1'b0, 1'b0, '0, 1'b0, got, lat, ax, bx);
    n_tests++; if (datapath_out !== 16'h0000) begin n_fail++; $display("FAIL cmp_c got=%h exp=0000", datapath_out); end
    n_tests++; if (status !== 3'b100) begin n_fail++; $display("FAIL cmp_status got=%b exp=100", status); end
    read_reg(3'd6, v, rgot);
    n_tests++; if (v !== 16'h1234) begin n_fail++; $display("FAIL cmp_r6_kept got=%h exp=1234", v); end
  endtask

  task automatic test_selectors_shift();
    logic got, rgot; int lat; logic [W-1:0] ax, bx, v;
    run_op(2'b00, 3'd2, 3'd2, 3'd1, 2'b00, 1'b1, 1'b1, 16'hFFFF, 1'b1, got, lat, ax, bx);
    n_tests++; if (datapath_out !== 16'hFFFF || status !== 3'b010) begin n_fail++; $display("FAIL sel_imm got=%h/%b exp=ffff/010", datapath_out, status); end
    read_reg(3'd1, v, rgot);
    n_tests++; if (v !== 16'hFFFF) begin n_fail++; $display("FAIL sel_r1 got=%h exp=ffff", v); end
    // R5 = 0x8000; ASR -> 0xC000; NOT -> 0x3FFF
    run_op(2'b11, 3'd0, 3'd5, 3'd7, 2'b11, 1'b0, 1'b0, '0, 1'b1, got, lat, ax, bx);
    n_tests++; if (bx !== 16'hC000) begin n_fail++; $display("FAIL asr_bin got=%h exp=c000", bx); end
    n_tests++; if (datapath_out !== 16'h3FFF || status !== 3'b000) begin n_fail++; $display("FAIL notb_c got=%h/%b exp=3fff/000", datapath_out, status); end
    read_reg(3'd7, v, rgot);
    n_tests++; if (v !== 16'h3FFF) begin n_fail++; $display("FAIL notb_r7 got=%h exp=3fff", v); end
    // LSR brings in zero at the top: R5=0x8000 -> 0x4000
    run_op(2'b00, 3'd0, 3'd5, 3'd0, 2'b10, 1'b1, 1'b0, '0, 1'b0, got, lat, ax, bx);
    n_tests++; if (datapath_out !== 16'h4000) begin n_fail++; $display("FAIL lsr_c got=%h exp=4000", datapath_out); end
  endtask

  task automatic test_busy_rules();
    logic rgot; logic [W-1:0] v;
    // ext write and start in the same IDLE cycle: LOAD_A sees the new R2
    op = 2'b00; rn = 3'd2; rm = 3'd0; rd = 3'd3; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0; sximm5 = '0; wb_en = 1'b1;
    start = 1'b1; ext_we = 1'b1; ext_wnum = 3'd2; ext_wdata = 16'h0050;
    tick();
    start = 1'b0; ext_we = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_loada got=%b exp=1", busy); end
    tick();
    // LOAD_B: second start and ext write must both be ignored
    op = 2'b11; rd = 3'd0; start = 1'b1; ext_we = 1'b1; ext_wnum = 3'd0; ext_wdata = 16'hAAAA;
    tick();
    start = 1'b0; ext_we = 1'b0;
    n_tests++; if (alu_valid !== 1'b1 || Ain !== 16'h0050 || Bin !== 16'h0007 || ALUop !== 2'b00) begin
      n_fail++; $display("FAIL busy_exec got=v%b %h %h op%b exp=v1 0050 0007 op00", alu_valid, Ain, Bin, ALUop); end
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL busy_done got=%b exp=1", done); end
    tick();
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_idle got=%b/%b exp=0/0", busy, done); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_queue got=%b exp=0", busy); end
    read_reg(3'd3, v, rgot);
    n_tests++; if (v !== 16'h0057) begin n_fail++; $display("FAIL busy_r3 got=%h exp=0057", v); end
    read_reg(3'd0, v, rgot);
    n_tests++; if (v !== 16'h0007) begin n_fail++; $display("FAIL busy_r0_kept got=%h exp=0007", v); end
  endtask

  task automatic test_reset_in_exec();
    logic rgot, saw_done; logic [W-1:0] v;
    op = 2'b00; rn = 3'd0; rm = 3'd1; rd = 3'd4; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0; wb_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    n_tests++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_exec got=%b exp=1", alu_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || alu_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_exec_flags got=%b%b%b exp=000", busy, done, alu_valid); end
    n_tests++; if (datapath_out !== 16'h0000 || status !== 3'b000) begin
      n_fail++; $display("FAIL rst_exec_c got=%h/%b exp=0000/000", datapath_out, status); end
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    n_tests++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done got=%b exp=0", saw_done); end
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), v, rgot);
      n_tests++; if (rgot !== 1'b1 || v !== 16'h0000) begin n_fail++; $display("FAIL rst_reg%0d got=%h exp=0000", r, v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shifted_add();
    test_overflow();
    test_compare_only();
    test_selectors_shift();
    test_busy_rules();
    test_reset_in_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
